cycle_meter: RTL and testbench

- Parametrised successor to the free-running 8-bit cycle register.
- Measures the number of clock cycles between a start and a stop event, with configurable width, a terminal limit, and saturate-or-wrap mode.
- A small control FSM holds the result and a sticky overflow flag, and emits a one-cycle done pulse.
- Sits beside the design FSMs as a latency/duration probe; its outputs are readable by the control logic or the testbench.

---
 rtl/cycle_meter_pkg.sv | 15 +
 rtl/cycle_count_core.sv | 47 ++++
 rtl/cycle_meter.sv | 108 ++++++++++
 tb/tb_cycle_meter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cycle_meter_pkg.sv
// Shared types for the cycle_meter duration probe.
// State encodings are pinned so debug views stay stable.
package cycle_meter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/cycle_count_core.sv
// Cycle counter with terminal limit and saturate-or-wrap behaviour.
// hit_limit strobes when an increment is attempted at LIMIT.
module cycle_count_core #(
    parameter int unsigned           WIDTH    = 8,
    parameter logic [WIDTH-1:0]      LIMIT    = {WIDTH{1'b1}},
    parameter bit                    SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_zero,
    input  logic             inc_en,
    output logic [WIDTH-1:0] count,
    output logic             hit_limit
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH:0]   sum;

    // Compare at full width so a LIMIT of all-ones cannot alias to zero.
    always_comb begin
        sum       = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};
        count_d   = count_q;
        hit_limit = 1'b0;
        if (load_zero) begin
            count_d = '0;
        end else if (inc_en) begin
            if (sum <= {1'b0, LIMIT}) begin
                count_d = sum[WIDTH-1:0];
            end else begin
                hit_limit = 1'b1;
                count_d   = SATURATE ? LIMIT : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cycle_meter.sv
// Start/stop duration probe: control FSM around cycle_count_core.
// Holds the captured result, a sticky overflow flag and a done pulse.
module cycle_meter
    import cycle_meter_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] LIMIT    = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] last_count,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    state_t           state_q;
    logic [WIDTH-1:0] last_q;
    logic             busy_q;
    logic             done_q;
    logic             ovf_q;
    logic             load_zero;
    logic             inc_en;
    logic             hit_limit;
    logic             in_run;

    assign in_run    = (state_q == RUN);
    assign load_zero = clear | (start & ~(in_run & stop));
    assign inc_en    = in_run & ~stop & ~start & ~clear;

    cycle_count_core #(
        .WIDTH    (WIDTH),
        .LIMIT    (LIMIT),
        .SATURATE (SATURATE)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .load_zero (load_zero),
        .inc_en    (inc_en),
        .count     (count),
        .hit_limit (hit_limit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (clear) begin
            state_q <= IDLE;
            last_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        ovf_q   <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_q <= DONE;
                        last_q  <= count;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (start) begin
                        ovf_q <= 1'b0;
                    end else if (hit_limit) begin
                        ovf_q <= 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        ovf_q   <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign last_count = last_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_cycle_meter.sv
// Bench for cycle_meter: three configurations driven in lockstep.
// An elapsed-cycles model predicts outputs; directed checks pin it.
module tb_cycle_meter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b1;
    logic stop = 1'b0;
    logic clear = 1'b0;

    always #5 clk = ~clk;

    logic [7:0] a_cnt, a_last;
    logic [3:0] b_cnt, b_last, c_cnt, c_last;
    logic a_busy, a_done, a_ovf;
    logic b_busy, b_done, b_ovf;
    logic c_busy, c_done, c_ovf;

    cycle_meter #(.WIDTH(8)) u_a (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .clear(clear), .count(a_cnt), .last_count(a_last),
        .busy(a_busy), .done(a_done), .overflow(a_ovf)
    );

    cycle_meter #(.WIDTH(4), .LIMIT(4'd15), .SATURATE(1'b1)) u_b (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .clear(clear), .count(b_cnt), .last_count(b_last),
        .busy(b_busy), .done(b_done), .overflow(b_ovf)
    );

    cycle_meter #(.WIDTH(4), .LIMIT(4'd15), .SATURATE(1'b0)) u_c (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .clear(clear), .count(c_cnt), .last_count(c_last),
        .busy(c_busy), .done(c_done), .overflow(c_ovf)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: mode 0=idle 1=run 2=done; n = cycles counted since start.
    int m_mode [3];
    int m_n    [3];
    int m_last [3];
    int m_lim  [3] = '{255, 15, 15};
    bit m_sat  [3] = '{1'b1, 1'b1, 1'b0};

    function automatic int mcount(int i);
        if (m_sat[i]) return (m_n[i] > m_lim[i]) ? m_lim[i] : m_n[i];
        return m_n[i] % (m_lim[i] + 1);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset || clear) begin
                m_mode[i] = 0;
                m_n[i]    = 0;
                m_last[i] = 0;
            end else if (m_mode[i] == 1) begin
                if (stop) begin
                    m_last[i] = mcount(i);
                    m_mode[i] = 2;
                end else if (start) begin
                    m_n[i] = 0;
                end else begin
                    m_n[i] = m_n[i] + 1;
                end
            end else if (start) begin
                m_mode[i] = 1;
                m_n[i]    = 0;
            end else begin
                m_mode[i] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_count", 32'(a_cnt), 32'(mcount(0)));
            chk("a_last", 32'(a_last), 32'(m_last[0]));
            chk("a_busy", 32'(a_busy), 32'(m_mode[0] == 1));
            chk("a_done", 32'(a_done), 32'(m_mode[0] == 2));
            chk("a_ovf", 32'(a_ovf), 32'(m_n[0] > m_lim[0]));
            chk("b_count", 32'(b_cnt), 32'(mcount(1)));
            chk("b_last", 32'(b_last), 32'(m_last[1]));
            chk("b_busy", 32'(b_busy), 32'(m_mode[1] == 1));
            chk("b_done", 32'(b_done), 32'(m_mode[1] == 2));
            chk("b_ovf", 32'(b_ovf), 32'(m_n[1] > m_lim[1]));
            chk("c_count", 32'(c_cnt), 32'(mcount(2)));
            chk("c_last", 32'(c_last), 32'(m_last[2]));
            chk("c_busy", 32'(c_busy), 32'(m_mode[2] == 1));
            chk("c_done", 32'(c_done), 32'(m_mode[2] == 2));
            chk("c_ovf", 32'(c_ovf), 32'(m_n[2] > m_lim[2]));
        end
    end

    task automatic tick(bit st = 0, bit sp = 0, bit cl = 0, bit rs = 0);
        start = st;
        stop  = sp;
        clear = cl;
        reset = rs;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        reset = 1'b0;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        // Reset dominates start for two edges.
        tick(1, 0, 0, 1);
        tick(1, 0, 0, 1);
        chk_en = 1'b1;
        chk("rst_count", 32'(a_cnt), 0);
        chk("rst_last", 32'(a_last), 0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_done", 32'(a_done), 0);
        chk("rst_ovf", 32'(b_ovf), 0);

        // Basic run of five counted cycles.
        tick(1);
        chk("start_busy", 32'(a_busy), 1);
        chk("start_count", 32'(a_cnt), 0);
        idle(5);
        chk("run5_count", 32'(a_cnt), 5);
        tick(0, 1);
        chk("stop_last", 32'(a_last), 5);
        chk("stop_done", 32'(a_done), 1);
        chk("stop_busy", 32'(a_busy), 0);
        tick();
        chk("post_done", 32'(a_done), 0);
        chk("post_busy", 32'(a_busy), 0);
        chk("hold_count", 32'(a_cnt), 5);

        // Saturate vs wrap across LIMIT.
        tick(1);
        idle(15);
        chk("sat15_count", 32'(b_cnt), 15);
        chk("sat15_ovf", 32'(b_ovf), 0);
        tick();
        chk("sat16_count", 32'(b_cnt), 15);
        chk("sat16_ovf", 32'(b_ovf), 1);
        chk("wrap16_count", 32'(c_cnt), 0);
        tick();
        chk("wrap17_count", 32'(c_cnt), 1);
        chk("wrap17_ovf", 32'(c_ovf), 1);
        chk("w8_17_count", 32'(a_cnt), 17);
        idle(3);
        chk("sat20_count", 32'(b_cnt), 15);
        tick(0, 1);
        chk("sat_last", 32'(b_last), 15);
        chk("wrap_last", 32'(c_last), 4);
        chk("ovf_sticky", 32'(c_ovf), 1);
        tick();
        chk("ovf_idle", 32'(b_ovf), 1);
        tick(1);
        chk("restart_count", 32'(c_cnt), 0);
        chk("restart_ovf", 32'(c_ovf), 0);

        // Start+stop together in RUN: stop wins.
        idle(7);
        tick(1, 1);
        chk("ss_done", 32'(a_done), 1);
        chk("ss_last", 32'(a_last), 7);
        tick(1);
        chk("done_start_busy", 32'(a_busy), 1);
        chk("done_start_count", 32'(a_cnt), 0);
        idle(2);
        tick(0, 1);
        chk("short_last", 32'(a_last), 2);
        tick();
        tick(0, 1);
        chk("idle_stop_done", 32'(a_done), 0);
        chk("idle_stop_last", 32'(a_last), 2);

        // Clear mid-run.
        tick(1);
        idle(3);
        chk("pre_clear", 32'(a_cnt), 3);
        tick(0, 0, 1);
        chk("clear_count", 32'(a_cnt), 0);
        chk("clear_last", 32'(a_last), 0);
        chk("clear_busy", 32'(a_busy), 0);
        chk("clear_done", 32'(a_done), 0);

        // Reset mid-run with stop asserted.
        tick(1);
        idle(9);
        chk("pre_reset", 32'(a_cnt), 9);
        tick(0, 1, 0, 1);
        chk("rst2_count", 32'(a_cnt), 0);
        chk("rst2_done", 32'(a_done), 0);
        chk("rst2_last", 32'(a_last), 0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
